prog_loader: RTL

- Writer side of the CPU instruction memory: receives a framed byte stream and writes WIDTH-bit instruction words into program RAM, which the fetch path then reads by PC.
- Holds the CPU (PC reset) until a complete, valid image is loaded.
- Sits between a host byte link (UART receiver or testbench) and the instruction RAM write port.

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader_word_asm.sv | 46 ++++
 rtl/prog_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and loader state encoding for the program loader.
// Optional checksum support is selected with PROG_LOADER_CHKSUM_EN.
package prog_loader_pkg;

  localparam int unsigned DefWidth    = 13;
  localparam int unsigned DefIwidth   = 5;
  localparam int unsigned DefAw       = DefWidth - DefIwidth;
  localparam logic [7:0]  DefSyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StHi,
    StLo,
    StChk,
    StDone,
    StError
  } ld_state_e;

  // A COUNT byte of zero stands for a full 2^AW-word image.
  function automatic int unsigned word_count(input logic [7:0] count);
    return (count == 8'd0) ? (32'd1 << DefAw) : {24'd0, count};
  endfunction

endpackage

// File: rtl/prog_loader_word_asm.sv
// Assembles HI/LO byte pairs into one instruction word and, when
// PROG_LOADER_CHKSUM_EN is defined, keeps the running XOR checksum.
module prog_loader_word_asm
  import prog_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             hi_en,
  input  logic             lo_en,
`ifdef PROG_LOADER_CHKSUM_EN
  input  logic             chk_clr,
  input  logic             chk_en,
  output logic [7:0]       chk,
`endif
  output logic [WIDTH-1:0] word
);

  // Only the HI bits that land in the word are kept.
  logic [WIDTH-9:0] hi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      word <= '0;
    end else begin
      if (hi_en) hi_q <= byte_in[WIDTH-9:0];
      if (lo_en) word <= {hi_q, byte_in};
    end
  end

`ifdef PROG_LOADER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk <= '0;
    end else if (chk_clr) begin
      chk <= '0;
    end else if (chk_en) begin
      chk <= chk ^ byte_in;
    end
  end
`endif

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the instruction RAM; holds the CPU until a
// full image is written. PROG_LOADER_CHKSUM_EN enables the trailing CHK byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned IWIDTH    = DefIwidth,
  parameter logic [7:0]  SYNC_BYTE = DefSyncByte,
  localparam int unsigned AW       = WIDTH - IWIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  ld_state_e   state_q;
  logic [AW:0] n_q;

  logic acc;
  logic is_sync;
  logic hi_en;
  logic lo_en;
  logic last;

  assign acc     = in_valid && in_ready;
  assign is_sync = (in_data == SYNC_BYTE);
  assign hi_en   = acc && (state_q == StHi);
  assign lo_en   = acc && (state_q == StLo);
  // wr_addr still holds the index of the word whose LO byte is arriving.
  assign last    = (({1'b0, wr_addr} + 1'b1) == n_q);

`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0] chk;
  logic       chk_clr;
  logic       chk_en;

  assign chk_clr = acc && is_sync && (state_q inside {StIdle, StDone, StError});
  assign chk_en  = acc && (state_q inside {StCount, StHi, StLo});
`else
  assign err = 1'b0;
`endif

  prog_loader_word_asm #(
    .WIDTH(WIDTH)
  ) u_word_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .byte_in(in_data),
    .hi_en  (hi_en),
    .lo_en  (lo_en),
`ifdef PROG_LOADER_CHKSUM_EN
    .chk_clr(chk_clr),
    .chk_en (chk_en),
    .chk    (chk),
`endif
    .word   (wr_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      n_q      <= '0;
      in_ready <= 1'b1;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      err      <= 1'b0;
`endif
    end else begin
      wr_en    <= 1'b0;
      in_ready <= 1'b1;
      if (wr_en) wr_addr <= wr_addr + 1'b1;

`ifndef PROG_LOADER_CHKSUM_EN
      // Without a CHK byte the image is complete once the last write retires.
      if (wr_en && (state_q == StDone)) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
`endif

      if (acc) begin
        unique case (state_q)
          StIdle, StDone, StError: begin
            if (is_sync) begin
              state_q  <= StCount;
              wr_addr  <= '0;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
              err      <= 1'b0;
`endif
            end
          end
          StCount: begin
            n_q     <= (AW+1)'(word_count(in_data));
            state_q <= StHi;
          end
          StHi: state_q <= StLo;
          StLo: begin
            // The write cycle blocks the next byte so it can never be lost.
            wr_en    <= 1'b1;
            in_ready <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
            state_q  <= last ? StChk : StHi;
`else
            state_q  <= last ? StDone : StHi;
`endif
          end
`ifdef PROG_LOADER_CHKSUM_EN
          StChk: begin
            if (in_data == chk) begin
              state_q  <= StDone;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_q  <= StError;
              err      <= 1'b1;
            end
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
